// File: rtl/sparse_pkg.sv
// rtl/sparse_pkg.sv - shared defaults and beat type for the sparse event path
package sparse_pkg;

    localparam int SPARSE_N_CH   = 16;
    localparam int SPARSE_ADDR_W = 8;
    localparam int SPARSE_CNT_W  = 8;

    // One address beat as seen by the serializer wrapper; "null" is a keyword, hence is_null
    typedef struct packed {
        logic [SPARSE_ADDR_W-1:0] addr;
        logic                     is_null;
        logic                     last;
    } sparse_beat_t;

endpackage

// File: rtl/lowest_set_encoder.sv
// rtl/lowest_set_encoder.sv - combinational index of the lowest set bit
module lowest_set_encoder
    import sparse_pkg::*;
#(
    parameter int N_CH   = SPARSE_N_CH,
    parameter int ADDR_W = SPARSE_ADDR_W
) (
    input  logic [N_CH-1:0]   vec,
    output logic [ADDR_W-1:0] idx,
    output logic              found
);

    // Scan from the top down so the lowest set bit is the last one written
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx   = ADDR_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sparse_event_encoder.sv
// rtl/sparse_event_encoder.sv - dense activity frame to sparse address beat stream
module sparse_event_encoder
    import sparse_pkg::*;
#(
    parameter int N_CH   = SPARSE_N_CH,
    parameter int ADDR_W = SPARSE_ADDR_W,
    parameter int CNT_W  = SPARSE_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [N_CH-1:0]   frame_in,
    input  logic              frame_valid,
    output logic              frame_ready,
    output logic [ADDR_W-1:0] addr_out,
    output logic              addr_null,
    output logic              addr_last,
    output logic              addr_valid,
    input  logic              addr_ready,
    output logic              busy,
    output logic [CNT_W-1:0]  frame_count
);

    logic [N_CH-1:0]   pending;
    logic              pend_null;
    logic [N_CH-1:0]   pending_cleared;
    logic [ADDR_W-1:0] lsb_idx;
    logic              lsb_found;
    logic              occupied;
    logic              slot_free;
    logic              accept;
    logic              load;
    logic              beat_done;

    lowest_set_encoder #(
        .N_CH   (N_CH),
        .ADDR_W (ADDR_W)
    ) u_lsb (
        .vec   (pending),
        .idx   (lsb_idx),
        .found (lsb_found)
    );

    // Handshake qualifiers; accept needs an empty pending stage, load needs a full one,
    // so the two never fire on the same edge
    always_comb begin
        occupied        = (|pending) | pend_null;
        frame_ready     = enable & ~occupied;
        accept          = frame_valid & frame_ready;
        slot_free       = ~addr_valid | addr_ready;
        load            = enable & slot_free & occupied;
        beat_done       = addr_valid & addr_ready & addr_last;
        pending_cleared = pending & ~(N_CH'(1) << lsb_idx);
        busy            = occupied | addr_valid;
    end

    // Pending stage: capture a frame, then peel off one set bit per loaded beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending   <= '0;
            pend_null <= 1'b0;
        end else if (accept) begin
            pending   <= frame_in;
            pend_null <= ~|frame_in;
        end else if (load) begin
            if (pend_null) begin
                pend_null <= 1'b0;
            end else begin
                pending <= pending_cleared;
            end
        end
    end

    // Output beat register: load the next beat when the slot frees, otherwise drop a consumed beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_out   <= '0;
            addr_null  <= 1'b0;
            addr_last  <= 1'b0;
            addr_valid <= 1'b0;
        end else if (load) begin
            addr_valid <= 1'b1;
            if (pend_null) begin
                addr_out  <= '0;
                addr_null <= 1'b1;
                addr_last <= 1'b1;
            end else if (lsb_found) begin
                addr_out  <= lsb_idx;
                addr_null <= 1'b0;
                addr_last <= ~|pending_cleared;
            end
        end else if (slot_free) begin
            addr_valid <= 1'b0;
        end
    end

    // Completed frames, counted on the handshake of each last beat; wraps naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_count <= '0;
        end else if (beat_done) begin
            frame_count <= frame_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_sparse_event_encoder.sv
// tb/tb_sparse_event_encoder.sv - directed self-checking bench for sparse_event_encoder
module tb_sparse_event_encoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b1;
    logic [15:0] frame_in = '0;
    logic        frame_valid = 1'b0;
    logic        frame_ready;
    logic [7:0]  addr_out;
    logic        addr_null;
    logic        addr_last;
    logic        addr_valid;
    logic        addr_ready = 1'b1;
    logic        busy;
    logic [7:0]  frame_count;

    int tests_run = 0;
    int tests_failed = 0;

    sparse_event_encoder #(
        .N_CH   (16),
        .ADDR_W (8),
        .CNT_W  (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .frame_in    (frame_in),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .addr_out    (addr_out),
        .addr_null   (addr_null),
        .addr_last   (addr_last),
        .addr_valid  (addr_valid),
        .addr_ready  (addr_ready),
        .busy        (busy),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a frame, wait (bounded) for frame_ready, and return just after the accept edge
    task automatic send_frame(input logic [15:0] data);
        int n = 0;
        frame_in    = data;
        frame_valid = 1'b1;
        while (!frame_ready && n < 50) begin
            step();
            n++;
        end
        tests_run++;
        if (!frame_ready) begin
            tests_failed++;
            $display("FAIL send_frame_timeout frame=%h frame_ready=%0b required 1", data, frame_ready);
        end
        step();
        frame_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        tests_run++;
        if ({addr_valid, addr_null, addr_last, busy} !== 4'b0000 || addr_out !== 8'd0 || frame_count !== 8'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs got v=%b n=%b l=%b busy=%b addr=%0d cnt=%0d required all 0",
                     addr_valid, addr_null, addr_last, busy, addr_out, frame_count);
        end
        tests_run++;
        if (frame_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_frame_ready got %b required 1", frame_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_null_frame();
        addr_ready = 1'b1;
        send_frame(16'h0000);
        tests_run++;
        if (addr_valid !== 1'b0 || busy !== 1'b1 || frame_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL null_after_accept got v=%b busy=%b fr=%b required 0,1,0", addr_valid, busy, frame_ready);
        end
        step();
        tests_run++;
        if ({addr_valid, addr_null, addr_last} !== 3'b111 || addr_out !== 8'd0) begin
            tests_failed++;
            $display("FAIL null_beat got v=%b n=%b l=%b addr=%0d required 1,1,1,0", addr_valid, addr_null, addr_last, addr_out);
        end
        step();
        tests_run++;
        if (addr_valid !== 1'b0 || frame_count !== 8'd1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL null_done got v=%b cnt=%0d busy=%b required 0,1,0", addr_valid, frame_count, busy);
        end
    endtask

    task automatic test_multi_beat();
        logic [7:0] exp_addr [4] = '{8'd0, 8'd5, 8'd10, 8'd15};
        send_frame(16'h8421);
        tests_run++;
        if (addr_valid !== 1'b0 || frame_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL multi_latency got v=%b fr=%b required 0,0", addr_valid, frame_ready);
        end
        for (int k = 0; k < 4; k++) begin
            step();
            tests_run++;
            if (addr_valid !== 1'b1 || addr_out !== exp_addr[k] || addr_null !== 1'b0 ||
                addr_last !== (k == 3) || frame_ready !== (k == 3)) begin
                tests_failed++;
                $display("FAIL multi_beat%0d got v=%b addr=%0d n=%b l=%b fr=%b required 1,%0d,0,%0b,%0b",
                         k, addr_valid, addr_out, addr_null, addr_last, frame_ready, exp_addr[k], k == 3, k == 3);
            end
        end
        step();
        tests_run++;
        if (addr_valid !== 1'b0 || frame_count !== 8'd2) begin
            tests_failed++;
            $display("FAIL multi_done got v=%b cnt=%0d required 0,2", addr_valid, frame_count);
        end
    endtask

    task automatic test_backpressure();
        addr_ready = 1'b0;
        send_frame(16'h0003);
        step();
        for (int k = 0; k < 5; k++) begin
            tests_run++;
            if (addr_valid !== 1'b1 || addr_out !== 8'd0 || addr_last !== 1'b0 || addr_null !== 1'b0) begin
                tests_failed++;
                $display("FAIL bp_hold%0d got v=%b addr=%0d l=%b n=%b required 1,0,0,0", k, addr_valid, addr_out, addr_last, addr_null);
            end
            step();
        end
        addr_ready = 1'b1;
        step();
        tests_run++;
        if (addr_valid !== 1'b1 || addr_out !== 8'd1 || addr_last !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_second got v=%b addr=%0d l=%b required 1,1,1", addr_valid, addr_out, addr_last);
        end
        step();
        tests_run++;
        if (addr_valid !== 1'b0 || frame_count !== 8'd3) begin
            tests_failed++;
            $display("FAIL bp_done got v=%b cnt=%0d required 0,3", addr_valid, frame_count);
        end
    endtask

    task automatic test_back_to_back();
        send_frame(16'h0001);
        frame_in    = 16'h0002;
        frame_valid = 1'b1;
        step();
        tests_run++;
        if (addr_valid !== 1'b1 || addr_out !== 8'd0 || addr_last !== 1'b1 || frame_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_first got v=%b addr=%0d l=%b fr=%b required 1,0,1,1", addr_valid, addr_out, addr_last, frame_ready);
        end
        step();
        frame_valid = 1'b0;
        tests_run++;
        if (addr_valid !== 1'b0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_bubble got v=%b busy=%b required 0,1", addr_valid, busy);
        end
        step();
        tests_run++;
        if (addr_valid !== 1'b1 || addr_out !== 8'd1 || addr_last !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_second got v=%b addr=%0d l=%b required 1,1,1", addr_valid, addr_out, addr_last);
        end
        step();
        tests_run++;
        if (addr_valid !== 1'b0 || frame_count !== 8'd5) begin
            tests_failed++;
            $display("FAIL b2b_done got v=%b cnt=%0d required 0,5", addr_valid, frame_count);
        end
    endtask

    task automatic test_enable_freeze();
        send_frame(16'h00F0);
        step();
        tests_run++;
        if (addr_valid !== 1'b1 || addr_out !== 8'd4) begin
            tests_failed++;
            $display("FAIL freeze_beat4 got v=%b addr=%0d required 1,4", addr_valid, addr_out);
        end
        enable = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tests_run++;
            if (frame_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL freeze_ready%0d got %b required 0", k, frame_ready);
            end
            step();
            tests_run++;
            if (addr_valid !== 1'b0 || busy !== 1'b1) begin
                tests_failed++;
                $display("FAIL freeze_idle%0d got v=%b busy=%b required 0,1", k, addr_valid, busy);
            end
        end
        enable = 1'b1;
        for (int k = 5; k <= 7; k++) begin
            step();
            tests_run++;
            if (addr_valid !== 1'b1 || addr_out !== 8'(k) || addr_last !== (k == 7)) begin
                tests_failed++;
                $display("FAIL freeze_resume%0d got v=%b addr=%0d l=%b required 1,%0d,%0b", k, addr_valid, addr_out, addr_last, k, k == 7);
            end
        end
        step();
        tests_run++;
        if (addr_valid !== 1'b0 || frame_count !== 8'd6) begin
            tests_failed++;
            $display("FAIL freeze_done got v=%b cnt=%0d required 0,6", addr_valid, frame_count);
        end
    endtask

    task automatic test_reset_and_wrap();
        send_frame(16'hFFFF);
        step();
        step();
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({addr_valid, addr_null, addr_last, busy} !== 4'b0000 || addr_out !== 8'd0 || frame_count !== 8'd0) begin
            tests_failed++;
            $display("FAIL midframe_reset got v=%b n=%b l=%b busy=%b addr=%0d cnt=%0d required all 0",
                     addr_valid, addr_null, addr_last, busy, addr_out, frame_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        for (int f = 1; f <= 256; f++) begin
            send_frame(16'h0001);
            step();
            step();
            if (f == 255) begin
                tests_run++;
                if (frame_count !== 8'd255) begin
                    tests_failed++;
                    $display("FAIL wrap_max got cnt=%0d required 255", frame_count);
                end
            end
        end
        tests_run++;
        if (frame_count !== 8'd0) begin
            tests_failed++;
            $display("FAIL wrap_zero got cnt=%0d required 0", frame_count);
        end
    endtask

    initial begin
        test_reset();
        test_null_frame();
        test_multi_beat();
        test_backpressure();
        test_back_to_back();
        test_enable_freeze();
        test_reset_and_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
